// File: rtl/frame_memory_pkg.sv
// Shared frame-buffer geometry, pixel format and colour codes.
package frame_memory_pkg;

  localparam int PX_WIDTH  = 160;
  localparam int PX_HEIGHT = 120;
  localparam int DEPTH     = PX_WIDTH * PX_HEIGHT;
  localparam int DW        = 3;
  localparam int AW        = 16;
  localparam int RAM_AW    = $clog2(DEPTH);

  typedef enum logic [DW-1:0] {
    BLACK   = 3'd0,
    BLUE    = 3'd1,
    GREEN   = 3'd2,
    CYAN    = 3'd3,
    RED     = 3'd4,
    MAGENTA = 3'd5,
    YELLOW  = 3'd6,
    WHITE   = 3'd7
  } colour_t;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction

endpackage

// File: rtl/fb_ram_1w2r.sv
// Plain 1-write / 2-read synchronous pixel RAM, read-first, 1-cycle read latency, no reset.
// Callers must keep write addresses in range; out-of-range read data is masked upstream.
module fb_ram_1w2r #(
  parameter int DW    = 3,
  parameter int DEPTH = 19200,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] din_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_a_q;
  logic [DW-1:0] rdata_b_q;

  // Reads sample the array before this edge's write lands: old data on a collision.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= din_i;
    end
    rdata_a_q <= mem_q[raddr_a_i];
    rdata_b_q <= mem_q[raddr_b_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/frame_memory.sv
// Pixel frame buffer, one write and two registered read ports (1-cycle latency, no backpressure).
// MEMORY_CLEAR_ON_RESET_EN: reset launches a DEPTH-cycle sweep that blanks every pixel.
module frame_memory
  import frame_memory_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [AW-1:0] raddr2,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] dout2
);

  logic              clearing;
  logic              wr_ok;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_a;
  logic [DW-1:0]     ram_b;
  logic              a_ok_q, a_ok_d;
  logic              b_ok_q, b_ok_d;

  assign wr_ok = we && addr_in_range(waddr) && !clearing;

`ifdef MEMORY_CLEAR_ON_RESET_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + RAM_AW'(1);
      if (ptr_q == RAM_AW'(DEPTH - 1)) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The sweep owns the write port; renderer writes are dropped until it finishes.
  assign clearing  = (state_q == ST_CLEAR);
  assign ram_we    = clearing || wr_ok;
  assign ram_waddr = clearing ? ptr_q : waddr[RAM_AW-1:0];
  assign ram_din   = clearing ? BLACK : din;
`else
  assign clearing  = 1'b0;
  assign ram_we    = wr_ok;
  assign ram_waddr = waddr[RAM_AW-1:0];
  assign ram_din   = din;
`endif

  fb_ram_1w2r #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .din_i     (ram_din),
    .raddr_a_i (raddr[RAM_AW-1:0]),
    .raddr_b_i (raddr2[RAM_AW-1:0]),
    .rdata_a_o (ram_a),
    .rdata_b_o (ram_b)
  );

  // Qualifier flags track the RAM read pipeline so reset, sweep and out-of-range all read black.
  assign a_ok_d = !clearing && addr_in_range(raddr);
  assign b_ok_d = !clearing && addr_in_range(raddr2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ok_q <= 1'b0;
      b_ok_q <= 1'b0;
    end else begin
      a_ok_q <= a_ok_d;
      b_ok_q <= b_ok_d;
    end
  end

  assign dout  = a_ok_q ? ram_a : BLACK;
  assign dout2 = b_ok_q ? ram_b : BLACK;

endmodule

// File: tb/tb_frame_memory.sv
// Directed bench for frame_memory: vector table plus reset / clear-sweep sequences.
module tb_frame_memory;

  localparam int DEPTH = 19200;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] waddr, raddr, raddr2;
  logic [2:0]  din;
  logic [2:0]  dout, dout2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [15:0] waddr;
    logic [2:0]  din;
    logic [15:0] raddr;
    logic [15:0] raddr2;
    logic        chk_a;
    logic [2:0]  exp_a;
    logic        chk_b;
    logic [2:0]  exp_b;
  } vec_t;

  vec_t vecs [16];

  frame_memory dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .raddr  (raddr),
    .raddr2 (raddr2),
    .din    (din),
    .dout   (dout),
    .dout2  (dout2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [15:0] wa, input logic [2:0] d,
                       input logic [15:0] ra, input logic [15:0] rb);
    we     = w;
    waddr  = wa;
    din    = d;
    raddr  = ra;
    raddr2 = rb;
  endtask

  initial begin
    // Inputs are applied at a negedge; the read result is checked at the next negedge.
    //              we  waddr  din raddr  raddr2 ca ea  cb eb
    vecs[0]  = '{1'b1, 16'd5,     3'd5, 16'd0,     16'd0,     1'b0, 3'd0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 16'd0,     3'd0, 16'd5,     16'd5,     1'b1, 3'd5, 1'b1, 3'd5};
    vecs[2]  = '{1'b1, 16'd10,    3'd0, 16'd5,     16'd5,     1'b1, 3'd5, 1'b1, 3'd5};
    vecs[3]  = '{1'b1, 16'd10,    3'd7, 16'd10,    16'd5,     1'b1, 3'd0, 1'b1, 3'd5};
    vecs[4]  = '{1'b0, 16'd0,     3'd0, 16'd10,    16'd10,    1'b1, 3'd7, 1'b1, 3'd7};
    vecs[5]  = '{1'b1, 16'd100,   3'd2, 16'd10,    16'd5,     1'b1, 3'd7, 1'b1, 3'd5};
    vecs[6]  = '{1'b1, 16'd200,   3'd6, 16'd100,   16'd5,     1'b1, 3'd2, 1'b1, 3'd5};
    vecs[7]  = '{1'b0, 16'd0,     3'd0, 16'd100,   16'd200,   1'b1, 3'd2, 1'b1, 3'd6};
    vecs[8]  = '{1'b1, 16'd0,     3'd3, 16'd100,   16'd200,   1'b1, 3'd2, 1'b1, 3'd6};
    vecs[9]  = '{1'b1, 16'd19200, 3'd7, 16'd19200, 16'd0,     1'b1, 3'd0, 1'b1, 3'd3};
    vecs[10] = '{1'b1, 16'd65535, 3'd1, 16'd65535, 16'd0,     1'b1, 3'd0, 1'b1, 3'd3};
    vecs[11] = '{1'b1, 16'd32773, 3'd2, 16'd5,     16'd19200, 1'b1, 3'd5, 1'b1, 3'd0};
    vecs[12] = '{1'b1, 16'd19199, 3'd4, 16'd5,     16'd0,     1'b1, 3'd5, 1'b1, 3'd3};
    vecs[13] = '{1'b0, 16'd19199, 3'd0, 16'd19199, 16'd19200, 1'b1, 3'd4, 1'b1, 3'd0};
    vecs[14] = '{1'b1, 16'd32768, 3'd6, 16'd0,     16'd19199, 1'b1, 3'd3, 1'b1, 3'd4};
    vecs[15] = '{1'b0, 16'd0,     3'd0, 16'd0,     16'd5,     1'b1, 3'd3, 1'b1, 3'd5};

    rst = 1'b1;
    drive(1'b0, 16'd0, 3'd0, 16'd0, 16'd0);
    #1;
    check("reset dout", dout, 3'd0);
    check("reset dout2", dout2, 3'd0);
    repeat (2) @(negedge clk);
    check("reset held dout", dout, 3'd0);
    check("reset held dout2", dout2, 3'd0);
    rst = 1'b0;
`ifdef MEMORY_CLEAR_ON_RESET_EN
    repeat (DEPTH) @(negedge clk);
`endif

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].din, vecs[i].raddr, vecs[i].raddr2);
      @(negedge clk);
      if (vecs[i].chk_a) check($sformatf("vec%0d dout", i), dout, vecs[i].exp_a);
      if (vecs[i].chk_b) check($sformatf("vec%0d dout2", i), dout2, vecs[i].exp_b);
    end

`ifdef MEMORY_CLEAR_ON_RESET_EN
    drive(1'b1, 16'd0, 3'd7, 16'd0, 16'd0);
    @(negedge clk);
    drive(1'b1, 16'd19199, 3'd7, 16'd0, 16'd0);
    @(negedge clk);
    drive(1'b0, 16'd0, 3'd0, 16'd0, 16'd19199);
    @(negedge clk);
    check("prefill addr0", dout, 3'd7);
    check("prefill addr19199", dout2, 3'd7);
    #2 rst = 1'b1;
    #1;
    check("clear rst async dout", dout, 3'd0);
    check("clear rst async dout2", dout2, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 16'd1, 3'd7, 16'd0, 16'd19199);
      @(negedge clk);
      if (k < 3 || k == DEPTH - 1) begin
        check($sformatf("sweep%0d dout", k), dout, 3'd0);
        check($sformatf("sweep%0d dout2", k), dout2, 3'd0);
      end
    end
    drive(1'b0, 16'd0, 3'd0, 16'd0, 16'd19199);
    @(negedge clk);
    check("after sweep addr0", dout, 3'd0);
    check("after sweep addr19199", dout2, 3'd0);
    drive(1'b0, 16'd0, 3'd0, 16'd1, 16'd19198);
    @(negedge clk);
    check("sweep write ignored addr1", dout, 3'd0);
    check("after sweep addr19198", dout2, 3'd0);
    drive(1'b1, 16'd1, 3'd5, 16'd0, 16'd0);
    @(negedge clk);
    drive(1'b0, 16'd0, 3'd0, 16'd1, 16'd1);
    @(negedge clk);
    check("post sweep write dout", dout, 3'd5);
    check("post sweep write dout2", dout2, 3'd5);
`else
    drive(1'b1, 16'd50, 3'd4, 16'd50, 16'd5);
    @(negedge clk);
    drive(1'b0, 16'd0, 3'd0, 16'd50, 16'd5);
    @(negedge clk);
    check("pre-rst addr50", dout, 3'd4);
    check("pre-rst addr5", dout2, 3'd5);
    #2 rst = 1'b1;
    #1;
    check("mid-cycle rst dout", dout, 3'd0);
    check("mid-cycle rst dout2", dout2, 3'd0);
    @(negedge clk);
    check("rst held dout", dout, 3'd0);
    check("rst held dout2", dout2, 3'd0);
    rst = 1'b0;
    drive(1'b1, 16'd60, 3'd6, 16'd50, 16'd5);
    @(negedge clk);
    check("retained addr50", dout, 3'd4);
    check("retained addr5", dout2, 3'd5);
    drive(1'b0, 16'd0, 3'd0, 16'd60, 16'd60);
    @(negedge clk);
    check("first write after rst dout", dout, 3'd6);
    check("first write after rst dout2", dout2, 3'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
